spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 29 ++
 rtl/spi_slave.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Parallel and serial signals of the SPI slave, grouped so the block and its
// master side (host logic or a bench) share one bundle.
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             i_cpol;
  logic             i_cpha;
  logic             i_sclk;
  logic             i_cs_n;
  logic             i_mosi;
  logic             o_miso;
  logic             o_miso_oe;
  logic [WIDTH-1:0] i_t_data;
  logic             i_t_ready;
  logic             o_t_full;
  logic             o_t_underrun;
  logic [WIDTH-1:0] o_r_data;
  logic             o_r_valid;

  modport slave (
    input  i_cpol, i_cpha, i_sclk, i_cs_n, i_mosi, i_t_data, i_t_ready,
    output o_miso, o_miso_oe, o_t_full, o_t_underrun, o_r_data, o_r_valid
  );

  modport master (
    output i_cpol, i_cpha, i_sclk, i_cs_n, i_mosi, i_t_data, i_t_ready,
    input  o_miso, o_miso_oe, o_t_full, o_t_underrun, o_r_data, o_r_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four modes, LSB first. SCLK/CS_n/MOSI are oversampled by the
// system clock through synchronizers; every output is a register.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  spi_slave_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_cpol;
  logic                   r_cpha;
  logic                   r_skip;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [WIDTH-1:0]       r_tx_shift;
  logic [WIDTH-2:0]       r_rx_shift;
  logic [WIDTH-1:0]       r_hold;
  logic                   r_t_full;
  logic                   r_t_underrun;
  logic [WIDTH-1:0]       r_r_data;
  logic                   r_r_valid;
  logic                   r_miso;
  logic                   r_miso_oe;

  logic             w_sclk_s;
  logic             w_cs_s;
  logic             w_mosi_s;
  logic             w_cs_fall;
  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_lead;
  logic             w_trail;
  logic             w_sample;
  logic             w_shift;
  logic             w_frame_done;
  logic             w_underrun;
  logic [WIDTH-1:0] w_rx_next;
  logic [WIDTH-1:0] w_load_word;

  assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall    = r_cs_d & ~w_cs_s;
  assign w_sclk_rise  = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall  = ~w_sclk_s & r_sclk_d;
  assign w_lead       = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail      = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample     = (r_state == ST_SHIFT) & ~w_cs_s & (r_cpha ? w_trail : w_lead);
  assign w_shift      = (r_state == ST_SHIFT) & ~w_cs_s & (r_cpha ? w_lead : w_trail);
  assign w_frame_done = w_sample & (r_bit_cnt == LAST_BIT);
  assign w_rx_next    = {w_mosi_s, r_rx_shift};
  assign w_underrun   = (r_state == ST_LOAD) & ~r_t_full & ~bus.i_t_ready;
  assign w_load_word  = r_t_full ? r_hold :
                        (bus.i_t_ready ? bus.i_t_data : {WIDTH{1'b0}});

  assign bus.o_miso       = r_miso;
  assign bus.o_miso_oe    = r_miso_oe;
  assign bus.o_t_full     = r_t_full;
  assign bus.o_t_underrun = r_t_underrun;
  assign bus.o_r_data     = r_r_data;
  assign bus.o_r_valid    = r_r_valid;

  // Input synchronizers and one-cycle-delayed copies for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // Frame sequencing; deselect wins over everything else
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_s) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_LOAD; else w_state_nxt = ST_IDLE;
        ST_LOAD:  w_state_nxt = ST_SHIFT;
        ST_SHIFT: if (w_frame_done) w_state_nxt = ST_LOAD; else w_state_nxt = ST_SHIFT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Transmit holding register; LOAD always empties it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold       <= {WIDTH{1'b0}};
      r_t_full     <= 1'b0;
      r_t_underrun <= 1'b0;
    end else begin
      r_t_underrun <= w_underrun;
      if (r_state == ST_LOAD) begin
        r_t_full <= 1'b0;
      end else if (bus.i_t_ready && !r_t_full) begin
        r_hold   <= bus.i_t_data;
        r_t_full <= 1'b1;
      end
    end
  end

  // Shift registers, bit counter, receive word and MISO drive.
  // r_tx_shift holds the bits still to come; r_miso is the bit on the wire.
  // r_skip swallows the first shift edge after LOAD: with CPHA=1 bit 0 is already
  // out, with CPHA=0 in a back-to-back frame it is the previous frame's last trailing edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_skip     <= 1'b0;
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_tx_shift <= {WIDTH{1'b0}};
      r_rx_shift <= {(WIDTH-1){1'b0}};
      r_r_data   <= {WIDTH{1'b0}};
      r_r_valid  <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
    end else begin
      r_r_valid <= w_frame_done;
      r_miso_oe <= (w_state_nxt != ST_IDLE);
      if (w_frame_done) begin
        r_r_data <= w_rx_next;
      end
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt  <= {CNT_W{1'b0}};
          r_tx_shift <= {WIDTH{1'b0}};
          r_rx_shift <= {(WIDTH-1){1'b0}};
          r_skip     <= 1'b0;
          r_miso     <= 1'b0;
        end
        ST_LOAD: begin
          r_bit_cnt  <= {CNT_W{1'b0}};
          r_tx_shift <= {1'b0, w_load_word[WIDTH-1:1]};
          r_miso     <= w_load_word[0];
          r_cpol     <= bus.i_cpol;
          r_cpha     <= bus.i_cpha;
          r_skip     <= bus.i_cpha | (w_sclk_s ^ bus.i_cpol);
        end
        ST_SHIFT: begin
          if (w_sample) begin
            r_rx_shift <= w_rx_next[WIDTH-1:1];
            r_bit_cnt  <= w_frame_done ? {CNT_W{1'b0}} : (r_bit_cnt + CNT_W'(1));
          end
          if (w_shift) begin
            if (r_skip) begin
              r_skip <= 1'b0;
            end else begin
              r_miso     <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[WIDTH-1:1]};
            end
          end
        end
        default: begin
          r_bit_cnt <= {CNT_W{1'b0}};
        end
      endcase
      if (w_state_nxt == ST_IDLE) begin
        r_miso    <= 1'b0;
        r_bit_cnt <= {CNT_W{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: modes 0 and 3, abort, back-to-back, underrun,
// mid-frame reset. A bit-banged master drives SCLK with 8-CLK half periods.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_if #(.WIDTH(W)) bus ();

  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         valid_cnt = 0;
  int         urun_cnt  = 0;
  logic [7:0] rx_log [0:63];

  // Count R_Valid / T_Underrun high cycles and log each received word
  always @(negedge clk) begin
    if (bus.o_r_valid) begin
      rx_log[valid_cnt % 64] = bus.o_r_data;
      valid_cnt++;
    end
    if (bus.o_t_underrun) urun_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    bus.i_t_data  = b;
    bus.i_t_ready = 1'b1;
    wait_clks(1);
    bus.i_t_ready = 1'b0;
    wait_clks(1);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    bus.i_cpol = pol;
    bus.i_cpha = pha;
    bus.i_sclk = pol;
    wait_clks(6);
  endtask

  task automatic cs_low();
    bus.i_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    bus.i_cs_n = 1'b1;
    wait_clks(2 * HALF);
  endtask

  // Master side of n bits: MOSI LSB first, MISO captured at the master's sample edge
  task automatic shift_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!bus.i_cpha) begin
        bus.i_mosi = mo[i];
        wait_clks(HALF);
        mi[i] = bus.o_miso;
        bus.i_sclk = ~bus.i_cpol;
        wait_clks(HALF);
        bus.i_sclk = bus.i_cpol;
      end else begin
        bus.i_sclk = ~bus.i_cpol;
        bus.i_mosi = mo[i];
        wait_clks(HALF);
        mi[i] = bus.o_miso;
        bus.i_sclk = bus.i_cpol;
        wait_clks(HALF);
      end
    end
  endtask

  logic [7:0] miso_a;
  logic [7:0] miso_b;
  int         v0;
  int         u0;

  initial begin
    bus.i_cpol = 1'b0;  bus.i_cpha = 1'b0;  bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;  bus.i_mosi = 1'b0;
    bus.i_t_data = 8'h00;  bus.i_t_ready = 1'b0;

    wait_clks(3);
    chk("rst_miso",    {31'd0, bus.o_miso},         32'd0);
    chk("rst_oe",      {31'd0, bus.o_miso_oe},      32'd0);
    chk("rst_tfull",   {31'd0, bus.o_t_full},       32'd0);
    chk("rst_underrun",{31'd0, bus.o_t_underrun},   32'd0);
    chk("rst_rdata",   {24'd0, bus.o_r_data},       32'd0);
    chk("rst_rvalid",  {31'd0, bus.o_r_valid},      32'd0);
    rst = 1'b0;
    wait_clks(4);

    // Mode 0: TX 0x3C (second load while full is ignored), RX 0xA5
    set_mode(1'b0, 1'b0);
    load_tx(8'h3C);
    chk("tfull_set", {31'd0, bus.o_t_full}, 32'd1);
    load_tx(8'hFF);
    v0 = valid_cnt;
    cs_low();
    chk("m0_oe_on", {31'd0, bus.o_miso_oe}, 32'd1);
    shift_bits(8'hA5, 8, miso_a);
    cs_high();
    chk("m0_miso",   {24'd0, miso_a},         32'h3C);
    chk("m0_rdata",  {24'd0, bus.o_r_data},   32'hA5);
    chk("m0_nvalid", valid_cnt - v0,          32'd1);
    chk("m0_oe_off", {31'd0, bus.o_miso_oe},  32'd0);
    chk("m0_miso_idle", {31'd0, bus.o_miso},  32'd0);

    // Mode 3: TX 0x81, RX 0x7E; SCLK goes high while deselected
    set_mode(1'b1, 1'b1);
    load_tx(8'h81);
    v0 = valid_cnt;
    cs_low();
    shift_bits(8'h7E, 8, miso_a);
    cs_high();
    chk("m3_miso",   {24'd0, miso_a},       32'h81);
    chk("m3_rdata",  {24'd0, bus.o_r_data}, 32'h7E);
    chk("m3_nvalid", valid_cnt - v0,        32'd1);

    // Abort after 4 bits, then a full 0x55 frame
    set_mode(1'b0, 1'b0);
    v0 = valid_cnt;
    cs_low();
    shift_bits(8'hFF, 4, miso_a);
    cs_high();
    chk("abort_nvalid", valid_cnt - v0,        32'd0);
    chk("abort_rdata",  {24'd0, bus.o_r_data}, 32'h7E);
    cs_low();
    shift_bits(8'h55, 8, miso_a);
    cs_high();
    chk("post_abort_rdata",  {24'd0, bus.o_r_data}, 32'h55);
    chk("post_abort_nvalid", valid_cnt - v0,        32'd1);

    // Back-to-back: 0x11 then 0x22 under one CS_n, RX 0x5A then 0xE7
    load_tx(8'h11);
    v0 = valid_cnt;
    cs_low();
    chk("b2b_tfull_clr", {31'd0, bus.o_t_full}, 32'd0);
    load_tx(8'h22);
    chk("b2b_tfull_set", {31'd0, bus.o_t_full}, 32'd1);
    shift_bits(8'h5A, 8, miso_a);
    shift_bits(8'hE7, 8, miso_b);
    cs_high();
    chk("b2b_miso0",  {24'd0, miso_a},          32'h11);
    chk("b2b_miso1",  {24'd0, miso_b},          32'h22);
    chk("b2b_nvalid", valid_cnt - v0,           32'd2);
    chk("b2b_rx0",    {24'd0, rx_log[v0 % 64]},       32'h5A);
    chk("b2b_rx1",    {24'd0, rx_log[(v0 + 1) % 64]}, 32'h E7);

    // Underrun: nothing loaded, MISO all zeros, RX still correct
    u0 = urun_cnt;
    v0 = valid_cnt;
    cs_low();
    chk("ur_pulses", urun_cnt - u0, 32'd1);
    shift_bits(8'h96, 8, miso_a);
    cs_high();
    chk("ur_miso",   {24'd0, miso_a},       32'h00);
    chk("ur_rdata",  {24'd0, bus.o_r_data}, 32'h96);
    chk("ur_nvalid", valid_cnt - v0,        32'd1);

    // Reset at bit 5 with a word pending, then a fresh 0xC3 frame
    v0 = valid_cnt;
    cs_low();
    load_tx(8'h5A);
    chk("mr_tfull_pre", {31'd0, bus.o_t_full}, 32'd1);
    shift_bits(8'hFF, 5, miso_a);
    rst = 1'b1;
    #1;
    chk("mr_miso",   {31'd0, bus.o_miso},       32'd0);
    chk("mr_oe",     {31'd0, bus.o_miso_oe},    32'd0);
    chk("mr_tfull",  {31'd0, bus.o_t_full},     32'd0);
    chk("mr_rdata",  {24'd0, bus.o_r_data},     32'd0);
    chk("mr_rvalid", {31'd0, bus.o_r_valid},    32'd0);
    bus.i_cs_n = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(HALF);
    chk("mr_nvalid", valid_cnt - v0, 32'd0);
    cs_low();
    shift_bits(8'hC3, 8, miso_a);
    cs_high();
    chk("mr_next_rdata",  {24'd0, bus.o_r_data}, 32'hC3);
    chk("mr_next_nvalid", valid_cnt - v0,        32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
